// File: rtl/banner_pkg.sv
// banner_pkg: shared FSM states, colour encodings and glyph ROM for msg_banner_bitmap.
package banner_pkg;
    typedef enum logic [1:0] {IDLE, REVEAL, SHOW} banner_state_t;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'h00;
    localparam logic [7:0] DEFAULT_INK = 8'hFF;
    localparam int ROM_W = 50;
    localparam int ROM_H = 20;
    localparam int ROM_MSGS = 4;
    typedef logic [ROM_MSGS-1:0][ROM_H-1:0][ROM_W-1:0] rom_t;
    // Diagonal stripe glyphs, phase-shifted per message; column 0 sits in the row MSB, 0 = ink.
    function automatic rom_t build_rom();
        rom_t rom;
        for (int m = 0; m < ROM_MSGS; m++)
            for (int y = 0; y < ROM_H; y++)
                for (int c = 0; c < ROM_W; c++)
                    rom[m][y][ROM_W-1-c] = ((c + 2 * y + m) % 5) != 0;
        return rom;
    endfunction
    localparam rom_t MSG_ROM = build_rom();
endpackage

// File: rtl/banner_glyph_rom.sv
// banner_glyph_rom: combinational glyph lookup with range check; ink=1 on a drawn ROM pixel.
module banner_glyph_rom import banner_pkg::*; #(
    parameter int BMP_W = ROM_W,
    parameter int BMP_H = ROM_H,
    parameter int NUM_MSGS = ROM_MSGS
) (
    input  logic [$clog2(NUM_MSGS)-1:0] msg,
    input  logic [10:0]                 by,
    input  logic [10:0]                 bx,
    output logic                        ink
);
    localparam int CW = $clog2(BMP_W);
    localparam int RW = $clog2(BMP_H);
    logic [ROM_W-1:0] row;
    logic [CW-1:0] col;
    assign row = MSG_ROM[msg][by[RW-1:0]];
    assign col = CW'(BMP_W - 1) - bx[CW-1:0];
    assign ink = (bx < 11'(BMP_W)) && (by < 11'(BMP_H)) && !row[col];
endmodule

// File: rtl/msg_banner_bitmap.sv
// msg_banner_bitmap: scaled glyph banner with frame-paced wipe-in reveal.
// Define BANNER_BLINK_EN to add a frame-counted blink while fully shown.
module msg_banner_bitmap import banner_pkg::*; #(
    parameter int BMP_W = ROM_W,
    parameter int BMP_H = ROM_H,
    parameter int NUM_MSGS = ROM_MSGS,
    parameter int SCALE_LOG2 = 0,
    parameter int REVEAL_STEP = 5
`ifdef BANNER_BLINK_EN
    , parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [10:0]                 offsetX,
    input  logic [10:0]                 offsetY,
    input  logic                        InsideRectangle,
    input  logic                        startOfFrame,
    input  logic                        show,
    input  logic [$clog2(NUM_MSGS)-1:0] msg_sel,
    input  logic [7:0]                  color_in,
    output logic [7:0]                  RGBout,
    output logic                        drawingRequest,
    output logic                        revealDone
);
    localparam int CW = $clog2(BMP_W + 1);
    localparam int MW = $clog2(NUM_MSGS);
    banner_state_t state, next_state;
    logic [CW-1:0] reveal_col, col_next, col_step;
    logic [MW-1:0] msg_q;
    logic [10:0] bx, by;
    logic rom_ink, visible, ink;
    logic [7:0] ink_col;

    assign bx = offsetX >> SCALE_LOG2;
    assign by = offsetY >> SCALE_LOG2;
    assign col_step = (int'(reveal_col) + REVEAL_STEP >= BMP_W) ? CW'(BMP_W) : CW'(int'(reveal_col) + REVEAL_STEP);

    banner_glyph_rom #(.BMP_W(BMP_W), .BMP_H(BMP_H), .NUM_MSGS(NUM_MSGS)) u_rom (
        .msg(msg_q),
        .by (by),
        .bx (bx),
        .ink(rom_ink)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = !show ? IDLE :
                     (state == IDLE) ? (REVEAL_STEP == 0 ? SHOW : REVEAL) :
                     (state == REVEAL && reveal_col == CW'(BMP_W)) ? SHOW : state;
        col_next = !show ? '0 :
                   (state == IDLE) ? (REVEAL_STEP == 0 ? CW'(BMP_W) : '0) :
                   (state == SHOW) ? CW'(BMP_W) :
                   startOfFrame ? col_step : reveal_col;
    end

    always_comb begin
        revealDone = (state == SHOW);
        ink = InsideRectangle && rom_ink && (bx < 11'(reveal_col)) && visible;
        ink_col = (color_in == TRANSPARENT_ENCODING) ? DEFAULT_INK : color_in;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            reveal_col <= '0;
            msg_q <= '0;
            RGBout <= TRANSPARENT_ENCODING;
        end else begin
            reveal_col <= col_next;
            if (state == IDLE && show) msg_q <= msg_sel;
            RGBout <= ink ? ink_col : TRANSPARENT_ENCODING;
        end

    assign drawingRequest = (RGBout != TRANSPARENT_ENCODING);

`ifdef BANNER_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [BW-1:0] blink_cnt;
    // Counter and phase restart whenever the banner is not settled in SHOW.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            blink_cnt <= '0;
            visible <= 1'b1;
        end else if (state != SHOW || !show) begin
            blink_cnt <= '0;
            visible <= 1'b1;
        end else if (startOfFrame) begin
            blink_cnt <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) visible <= ~visible;
        end
`else
    assign visible = 1'b1;
`endif
endmodule

// File: tb/tb_msg_banner_bitmap.sv
// tb_msg_banner_bitmap: directed scoreboard bench for msg_banner_bitmap (SCALE_LOG2=1).
module tb_msg_banner_bitmap;
    logic clk = 1'b0, reset = 1'b1, InsideRectangle = 1'b0, startOfFrame = 1'b0, show = 1'b0;
    logic [10:0] offsetX = '0, offsetY = '0;
    logic [1:0] msg_sel = '0;
    logic [7:0] color_in = 8'h1C, RGBout;
    logic drawingRequest, revealDone;
    int n_assert = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    string tag_q[$];

    msg_banner_bitmap #(
        .SCALE_LOG2(1)
`ifdef BANNER_BLINK_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .startOfFrame(startOfFrame), .show(show),
        .msg_sel(msg_sel), .color_in(color_in), .RGBout(RGBout),
        .drawingRequest(drawingRequest), .revealDone(revealDone)
    );

    always #5 clk = ~clk;

    function automatic logic glyph(input int m, input int x, input int y);
        return x < 50 && y < 20 && ((x + 2 * y + m) % 5) == 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    // Drive one screen pixel, queue its expected colour, compare after the output register.
    task automatic probe(input string tag, input int x, input int y, input logic ins,
                         input logic [7:0] col, input int rcol, input logic vis, input int m);
        logic [7:0] e;
        string t;
        offsetX = 11'(x);
        offsetY = 11'(y);
        InsideRectangle = ins;
        color_in = col;
        exp_q.push_back((ins && vis && (x >> 1) < rcol && glyph(m, x >> 1, y >> 1)) ?
                        ((col == 8'h00) ? 8'hFF : col) : 8'h00);
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, RGBout, e);
        chk({t, "_req"}, 8'(drawingRequest), 8'(e != 8'h00));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic vis;
`ifdef BANNER_BLINK_EN
        logic [4:0] vis_pat;
        vis_pat = 5'b10011;
`endif
        tick();
        tick();
        chk("rst_rgb", RGBout, 8'h00);
        chk("rst_req", 8'(drawingRequest), 8'h00);
        chk("rst_done", 8'(revealDone), 8'h00);
        reset = 1'b0;
        msg_sel = 2'd0;
        show = 1'b1;
        tick();
        msg_sel = 2'd2;
        probe("rev0", 24, 8, 1'b1, 8'h1C, 0, 1'b1, 0);
        for (int k = 1; k <= 10; k++) begin
            frame();
            if (k == 10) chk("done_early", 8'(revealDone), 8'h00);
            probe($sformatf("rev%0d", k), 24, 8, 1'b1, 8'h1C, 5 * k, 1'b1, 0);
        end
        chk("done", 8'(revealDone), 8'h01);
        probe("scale_49_19", 99, 39, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("scale_47_19", 95, 39, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("scale_x100", 100, 39, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("scale_y40", 94, 40, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("ink_col00", 30, 0, 1'b1, 8'h00, 50, 1'b1, 0);
        probe("ink_col1c", 30, 0, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("bg_col00", 32, 0, 1'b1, 8'h00, 50, 1'b1, 0);
        probe("bg_col1c", 32, 0, 1'b1, 8'h1C, 50, 1'b1, 0);
        probe("outside", 30, 0, 1'b0, 8'h1C, 50, 1'b1, 0);
        for (int f = 0; f < 5; f++) begin
            vis = 1'b1;
`ifdef BANNER_BLINK_EN
            vis = vis_pat[f];
`endif
            probe($sformatf("blink%0d", f), 30, 0, 1'b1, 8'h1C, 50, vis, 0);
            frame();
        end
        show = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("abort_done", 8'(revealDone), 8'h00);
        probe("abort_idle", 30, 0, 1'b1, 8'h1C, 0, 1'b1, 0);
        msg_sel = 2'd2;
        show = 1'b1;
        tick();
        frame();
        frame();
        probe("msg2_ink", 6, 0, 1'b1, 8'h1C, 10, 1'b1, 2);
        probe("msg2_bg", 0, 0, 1'b1, 8'h1C, 10, 1'b1, 2);
        show = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        probe("drop_sof", 6, 0, 1'b1, 8'h1C, 0, 1'b1, 2);
        show = 1'b1;
        tick();
        probe("drop_col0", 6, 0, 1'b1, 8'h1C, 0, 1'b1, 2);
        frame();
        probe("pre_rst", 6, 0, 1'b1, 8'h1C, 5, 1'b1, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_rgb", RGBout, 8'h00);
        chk("rst_mid_req", 8'(drawingRequest), 8'h00);
        chk("rst_mid_done", 8'(revealDone), 8'h00);
        tick();
        reset = 1'b0;
        msg_sel = 2'd1;
        tick();
        probe("post_rst_col0", 8, 0, 1'b1, 8'h1C, 0, 1'b1, 1);
        frame();
        probe("post_rst_msg1", 8, 0, 1'b1, 8'h1C, 5, 1'b1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
